// File: rtl/cpu_pkg.sv
// Shared core-wide types and constants; the fetch stage contributes its buffer entry,
// its FSM states and the canonical NOP encoding.
package cpu_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } t_fetch_entry;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } t_fetch_state;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch stage for both the request pc tags and the
// returned {pc, inst} entries. Flush empties it in one cycle; the head is read combinationally.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output T                         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned memory requests, buffers the
// responses with their PCs and hands them to decode; a redirect flushes and drains stale responses.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    t_fetch_state  state;
    t_fetch_state  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_cnt_next;
    logic [CW-1:0] count;
    logic [CW-1:0] tag_count;
    logic [CW:0]   in_use;

    logic          req_fire;
    logic          rsp_fire;
    logic          pop;
    logic          redirect;
    logic          push_tag;
    logic          pop_tag;
    logic          push_inst;
    logic          tag_empty;
    logic          tag_full;
    logic          inst_empty;
    logic          inst_full;
    logic [31:0]   tag_head;
    t_fetch_entry  entry_in;
    t_fetch_entry  entry_head;
    logic          unused_status;

    assign redirect         = redirect_valid & (state != S_BOOT);
    assign req_fire         = imem_req_valid & imem_req_ready;
    assign rsp_fire         = imem_rsp_valid;
    assign pop              = inst_valid & inst_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);
    assign in_use           = {1'b0, outstanding} + {1'b0, count};

    assign imem_req_addr = fetch_pc;
    assign inst_valid    = ~inst_empty;
    assign inst          = entry_head.inst;
    assign inst_pc       = entry_head.pc;
    assign entry_in.pc   = tag_head;
    assign entry_in.inst = imem_rsp_data;

    assign unused_status = ^{tag_count, tag_full, inst_full, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
        end
    end

    // Requests are throttled so in-flight plus buffered never exceeds DEPTH, hence no
    // response can ever find the instruction FIFO full.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_cnt_next  = drop_cnt;
        imem_req_valid = 1'b0;
        push_tag       = 1'b0;
        pop_tag        = 1'b0;
        push_inst      = 1'b0;

        case (state)
            S_BOOT: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                imem_req_valid = (in_use < (CW+1)'(DEPTH));
                push_tag       = req_fire;
                pop_tag        = rsp_fire;
                push_inst      = rsp_fire & ~tag_empty;
                if (req_fire) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                end
            end
            S_FLUSH: begin
                drop_cnt_next = drop_cnt - CW'(rsp_fire);
                if ((drop_cnt - CW'(rsp_fire)) == '0) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase

        // Everything in flight at the redirect, including a request accepted this very
        // cycle, belongs to the old path and must be swallowed before fetching resumes.
        if (redirect) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            drop_cnt_next = outstanding_next;
            push_tag      = 1'b0;
            pop_tag       = 1'b0;
            push_inst     = 1'b0;
            state_next    = (outstanding_next != '0) ? S_FLUSH : S_RUN;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [31:0])
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_tag),
        .push_data (fetch_pc),
        .pop       (pop_tag),
        .flush     (redirect),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (t_fetch_entry)
    ) u_inst_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_inst),
        .push_data (entry_in),
        .pop       (pop),
        .flush     (redirect),
        .head      (entry_head),
        .count     (count),
        .empty     (inst_empty),
        .full      (inst_full)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable in-order memory model plus
// hand-derived cycle-by-cycle expectations for fetch, stall, backpressure, redirect and reset.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;
    int latency = 1;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } t_pend;

    t_pend       pend[$];
    logic [31:0] reqlog[$];
    logic [31:0] popped_pc[$];
    logic [31:0] popped_inst[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hCAFE_0000 | (a >> 2);
    endfunction

    // Memory model and pop monitor: all inputs are stable at the falling edge, so the
    // cycle's fires are decided here and the response for this cycle is driven here.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            cyc            = 0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(pend[0].addr);
                void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + latency});
                reqlog.push_back(imem_req_addr);
            end
            if (inst_valid && inst_ready) begin
                popped_pc.push_back(inst_pc);
                popped_inst.push_back(inst);
            end
            cyc++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic req_rdy, input logic ird,
                                 input logic rv, input logic [31:0] rpc);
        imem_req_ready = req_rdy;
        inst_ready     = ird;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string prefix);
        checkOutput({prefix, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        checkOutput({prefix, "_req_addr"}, imem_req_addr, RESET_PC);
        checkOutput({prefix, "_inst_valid"}, 32'(inst_valid), 32'd0);
        checkOutput({prefix, "_inst"}, inst, 32'd0);
        checkOutput({prefix, "_inst_pc"}, inst_pc, 32'd0);
    endtask

    // Leaves the bench in cycle 0 (the S_BOOT cycle) with rst_n high.
    task automatic releaseReset();
        rst_n = 1'b1;
        reqlog.delete();
        popped_pc.delete();
        popped_inst.delete();
    endtask

    task automatic startFromReset(input int lat, input bool_check);
        rst_n   = 1'b0;
        latency = lat;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick(2);
        if (bool_check) checkReset("rst");
        releaseReset();
    endtask

    initial begin
        int bad;

        // Straight-line fetch with 1-cycle memory
        startFromReset(1, 1'b1);
        checkOutput("t1_boot_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        checkOutput("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t1_c1_req_addr", imem_req_addr, RESET_PC);
        tick();
        checkOutput("t1_c2_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("t1_c3_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("t1_c3_inst_pc", inst_pc, 32'h0);
        checkOutput("t1_c3_inst", inst, memWord(32'h0));
        tick(8);
        checkOutput("t1_pop_count", 32'(popped_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1_pc%0d", i), popped_pc[i], 32'(i * 4));
            checkOutput($sformatf("t1_inst%0d", i), popped_inst[i], memWord(32'(i * 4)));
        end

        // Memory not ready for 5 cycles while address 0x4 is pending
        startFromReset(1, 1'b0);
        tick(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("t2_hold_valid%0d", k), 32'(imem_req_valid), 32'd1);
            checkOutput($sformatf("t2_hold_addr%0d", k), imem_req_addr, 32'h4);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t2_req%0d", i), reqlog[i], 32'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t2_pc%0d", i), popped_pc[i], 32'(i * 4));
        end

        // Decoder backpressure fills the buffer at DEPTH=2
        startFromReset(1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        tick(6);
        checkOutput("t3_full_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("t3_full_req_count", 32'(reqlog.size()), 32'd2);
        checkOutput("t3_full_inst_pc", inst_pc, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        tick(10);
        checkOutput("t3_pc0", popped_pc[0], 32'h0);
        checkOutput("t3_pc1", popped_pc[1], 32'h4);
        checkOutput("t3_pc2", popped_pc[2], 32'h8);
        checkOutput("t3_req2", reqlog[2], 32'h8);

        // 3-cycle memory, redirect to 0x100 with 0x8 and 0xC in flight
        startFromReset(3, 1'b0);
        tick(8);
        checkOutput("t4_c8_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("t4_c8_req_count", 32'(reqlog.size()), 32'd4);
        checkOutput("t4_c8_pop_count", 32'(popped_pc.size()), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t4_c9_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        checkOutput("t4_c10_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        checkOutput("t4_c11_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t4_c11_req_addr", imem_req_addr, 32'h100);
        tick(12);
        checkOutput("t4_pc0", popped_pc[0], 32'h0);
        checkOutput("t4_pc1", popped_pc[1], 32'h4);
        checkOutput("t4_pc2", popped_pc[2], 32'h100);
        checkOutput("t4_inst2", popped_inst[2], memWord(32'h100));
        bad = 0;
        foreach (popped_pc[i]) begin
            if (popped_pc[i] == 32'h8 || popped_pc[i] == 32'hC) bad++;
        end
        checkOutput("t4_no_stale_pc", 32'(bad), 32'd0);

        // Redirect to 0x203 coinciding with a response and a request accept
        startFromReset(1, 1'b0);
        tick(2);
        checkOutput("t5_c2_req_valid", 32'(imem_req_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h203);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t5_c3_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("t5_c3_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        checkOutput("t5_c4_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t5_c4_req_addr", imem_req_addr, 32'h200);
        tick(6);
        checkOutput("t5_pc0", popped_pc[0], 32'h200);
        checkOutput("t5_req2", reqlog[2], 32'h200);

        // Reset pulse while draining stale responses
        startFromReset(3, 1'b0);
        tick(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("t6_flush_req_valid", 32'(imem_req_valid), 32'd0);
        rst_n = 1'b0;
        tick();
        checkReset("t6_rst");
        releaseReset();
        checkOutput("t6_boot_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        checkOutput("t6_c1_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t6_c1_req_addr", imem_req_addr, RESET_PC);
        tick(10);
        checkOutput("t6_pc0", popped_pc[0], RESET_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
